// File: rtl/device_arbiter.sv
// Two-requester round-robin arbiter in front of a single device port; one transaction in flight.
// Optional WAIT-state timeout that synthesizes a 32'hDEADBEEF response: define DEVICE_ARB_TIMEOUT_EN.
module device_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in0_req_valid,
  output logic        in0_req_ready,
  input  logic [31:0] in0_req_bits_addr,
  input  logic [31:0] in0_req_bits_data,
  input  logic [1:0]  in0_req_bits_len,
  input  logic        in0_req_bits_fcn,
  input  logic [3:0]  in0_req_bits_wstrb,
  input  logic        in0_req_bits_is_cached,
  input  logic        in0_req_bits_s1_kill,
  output logic        in0_resp_valid,
  input  logic        in0_resp_ready,
  output logic [31:0] in0_resp_bits_data,

  input  logic        in1_req_valid,
  output logic        in1_req_ready,
  input  logic [31:0] in1_req_bits_addr,
  input  logic [31:0] in1_req_bits_data,
  input  logic [1:0]  in1_req_bits_len,
  input  logic        in1_req_bits_fcn,
  input  logic [3:0]  in1_req_bits_wstrb,
  input  logic        in1_req_bits_is_cached,
  input  logic        in1_req_bits_s1_kill,
  output logic        in1_resp_valid,
  input  logic        in1_resp_ready,
  output logic [31:0] in1_resp_bits_data,

  output logic        out_req_valid,
  input  logic        out_req_ready,
  output logic [31:0] out_req_bits_addr,
  output logic [31:0] out_req_bits_data,
  output logic [1:0]  out_req_bits_len,
  output logic        out_req_bits_fcn,
  output logic [3:0]  out_req_bits_wstrb,
  output logic        out_req_bits_is_cached,
  output logic        out_req_bits_s1_kill,
  output logic        out_resp_ready,
  input  logic        out_resp_valid,
  input  logic [31:0] out_resp_bits_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;    // 1: in1 wins a tie
  logic        owner_q, owner_d;
  logic        first_q, first_d;  // first REQ cycle, when s1_kill applies
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  len_q, len_d;
  logic        fcn_q, fcn_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        cached_q, cached_d;

  logic grant0, grant1, kill_owner, timeout_hit;

  assign grant0     = in0_req_valid && (!in1_req_valid || !prio_q);
  assign grant1     = in1_req_valid && !grant0;
  assign kill_owner = owner_q ? in1_req_bits_s1_kill : in0_req_bits_s1_kill;

`ifdef DEVICE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (state_q == ST_WAIT && !out_resp_valid && !timeout_hit) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      len_q    <= '0;
      fcn_q    <= 1'b0;
      wstrb_q  <= '0;
      cached_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      first_q  <= first_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      len_q    <= len_d;
      fcn_q    <= fcn_d;
      wstrb_q  <= wstrb_d;
      cached_q <= cached_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    first_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    len_d    = len_q;
    fcn_d    = fcn_q;
    wstrb_d  = wstrb_q;
    cached_d = cached_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          state_d  = ST_REQ;
          owner_d  = grant1;
          prio_d   = grant0;
          first_d  = 1'b1;
          addr_d   = grant1 ? in1_req_bits_addr      : in0_req_bits_addr;
          wdata_d  = grant1 ? in1_req_bits_data      : in0_req_bits_data;
          len_d    = grant1 ? in1_req_bits_len       : in0_req_bits_len;
          fcn_d    = grant1 ? in1_req_bits_fcn       : in0_req_bits_fcn;
          wstrb_d  = grant1 ? in1_req_bits_wstrb     : in0_req_bits_wstrb;
          cached_d = grant1 ? in1_req_bits_is_cached : in0_req_bits_is_cached;
        end
      end
      ST_REQ: begin
        if (first_q && kill_owner) state_d = ST_IDLE;
        else if (out_req_ready)    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (out_resp_valid) begin
          rdata_d = out_resp_bits_data;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rdata_d = 32'hDEADBEEF;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q ? in1_resp_ready : in0_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are gated by reset so they read 0 while it is held.
  always_comb begin
    in0_req_ready          = reset && (state_q == ST_IDLE) && grant0;
    in1_req_ready          = reset && (state_q == ST_IDLE) && grant1;
    out_req_valid          = reset && (state_q == ST_REQ) && !(first_q && kill_owner);
    out_resp_ready         = reset && (state_q != ST_RESP);
    in0_resp_valid         = reset && (state_q == ST_RESP) && !owner_q;
    in1_resp_valid         = reset && (state_q == ST_RESP) && owner_q;
    in0_resp_bits_data     = rdata_q;
    in1_resp_bits_data     = rdata_q;
    out_req_bits_addr      = addr_q;
    out_req_bits_data      = wdata_q;
    out_req_bits_len       = len_q;
    out_req_bits_fcn       = fcn_q;
    out_req_bits_wstrb     = wstrb_q;
    out_req_bits_is_cached = cached_q;
    out_req_bits_s1_kill   = 1'b0;
  end

endmodule

// File: tb/tb_device_arbiter.sv
// Directed bench for device_arbiter: scoreboard of expected responses, immediate assertions.
// The timeout scenario runs only when DEVICE_ARB_TIMEOUT_EN is defined.
module tb_device_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_req_valid, in0_req_ready, in0_req_bits_fcn, in0_req_bits_is_cached, in0_req_bits_s1_kill;
  logic [31:0] in0_req_bits_addr, in0_req_bits_data, in0_resp_bits_data;
  logic [1:0]  in0_req_bits_len;
  logic [3:0]  in0_req_bits_wstrb;
  logic        in0_resp_valid, in0_resp_ready;
  logic        in1_req_valid, in1_req_ready, in1_req_bits_fcn, in1_req_bits_is_cached, in1_req_bits_s1_kill;
  logic [31:0] in1_req_bits_addr, in1_req_bits_data, in1_resp_bits_data;
  logic [1:0]  in1_req_bits_len;
  logic [3:0]  in1_req_bits_wstrb;
  logic        in1_resp_valid, in1_resp_ready;
  logic        out_req_valid, out_req_ready, out_req_bits_fcn, out_req_bits_is_cached, out_req_bits_s1_kill;
  logic [31:0] out_req_bits_addr, out_req_bits_data;
  logic [1:0]  out_req_bits_len;
  logic [3:0]  out_req_bits_wstrb;
  logic        out_resp_ready, out_resp_valid;
  logic [31:0] out_resp_bits_data;

  always #5 clk = ~clk;

  device_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .in0_req_valid(in0_req_valid), .in0_req_ready(in0_req_ready),
    .in0_req_bits_addr(in0_req_bits_addr), .in0_req_bits_data(in0_req_bits_data),
    .in0_req_bits_len(in0_req_bits_len), .in0_req_bits_fcn(in0_req_bits_fcn),
    .in0_req_bits_wstrb(in0_req_bits_wstrb), .in0_req_bits_is_cached(in0_req_bits_is_cached),
    .in0_req_bits_s1_kill(in0_req_bits_s1_kill),
    .in0_resp_valid(in0_resp_valid), .in0_resp_ready(in0_resp_ready), .in0_resp_bits_data(in0_resp_bits_data),
    .in1_req_valid(in1_req_valid), .in1_req_ready(in1_req_ready),
    .in1_req_bits_addr(in1_req_bits_addr), .in1_req_bits_data(in1_req_bits_data),
    .in1_req_bits_len(in1_req_bits_len), .in1_req_bits_fcn(in1_req_bits_fcn),
    .in1_req_bits_wstrb(in1_req_bits_wstrb), .in1_req_bits_is_cached(in1_req_bits_is_cached),
    .in1_req_bits_s1_kill(in1_req_bits_s1_kill),
    .in1_resp_valid(in1_resp_valid), .in1_resp_ready(in1_resp_ready), .in1_resp_bits_data(in1_resp_bits_data),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_bits_addr(out_req_bits_addr), .out_req_bits_data(out_req_bits_data),
    .out_req_bits_len(out_req_bits_len), .out_req_bits_fcn(out_req_bits_fcn),
    .out_req_bits_wstrb(out_req_bits_wstrb), .out_req_bits_is_cached(out_req_bits_is_cached),
    .out_req_bits_s1_kill(out_req_bits_s1_kill),
    .out_resp_ready(out_resp_ready), .out_resp_valid(out_resp_valid), .out_resp_bits_data(out_resp_bits_data)
  );

  typedef struct { int owner; logic [31:0] data; } exp_t;
  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur_owner;
  logic [31:0] exp_addr[2];
  logic [31:0] exp_wdata[2];
  logic [7:0]  exp_attr[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input int who, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] len, input logic fcn, input logic [3:0] wstrb, input logic cached);
    if (who == 0) begin
      in0_req_valid = 1'b1; in0_req_bits_addr = addr; in0_req_bits_data = data;
      in0_req_bits_len = len; in0_req_bits_fcn = fcn; in0_req_bits_wstrb = wstrb; in0_req_bits_is_cached = cached;
    end else begin
      in1_req_valid = 1'b1; in1_req_bits_addr = addr; in1_req_bits_data = data;
      in1_req_bits_len = len; in1_req_bits_fcn = fcn; in1_req_bits_wstrb = wstrb; in1_req_bits_is_cached = cached;
    end
    exp_addr[who]  = addr;
    exp_wdata[who] = data;
    exp_attr[who]  = {len, fcn, wstrb, cached};
  endtask

  // Waits (bounded) for a grant, checks the winner, then takes the acceptance edge.
  task automatic wait_grant(input int exp_who);
    int n = 0;
    #1;
    while (!in0_req_ready && !in1_req_ready && n < 20) begin
      tick(); #1; n++;
    end
    check("grant_seen", {31'd0, in0_req_ready | in1_req_ready}, 32'd1);
    check("grant_id", {31'd0, in1_req_ready}, exp_who);
    check("grant_onehot", {31'd0, in0_req_ready & in1_req_ready}, 32'd0);
    cur_owner = exp_who;
    tick();
    if (exp_who == 0) in0_req_valid = 1'b0;
    else              in1_req_valid = 1'b0;
  endtask

  function automatic logic [7:0] out_attr();
    return {out_req_bits_len, out_req_bits_fcn, out_req_bits_wstrb, out_req_bits_is_cached};
  endfunction

  // Carries an accepted request through REQ, WAIT and RESP.
  task automatic serve(input int req_stall, input int dev_delay, input logic [31:0] rdata, input int resp_stall);
    int    own = cur_owner;
    int    n = 0;
    exp_t  e;
    logic  v_own, v_oth;
    logic [31:0] d_own;
    out_req_ready = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      #1;
      check("req_valid_stall", {31'd0, out_req_valid}, 32'd1);
      check("req_addr_stall", out_req_bits_addr, exp_addr[own]);
      check("req_attr_stall", {24'd0, out_attr()}, {24'd0, exp_attr[own]});
      tick();
    end
    out_req_ready = 1'b1;
    #1;
    check("req_valid", {31'd0, out_req_valid}, 32'd1);
    check("req_addr", out_req_bits_addr, exp_addr[own]);
    check("req_wdata", out_req_bits_data, exp_wdata[own]);
    check("req_attr", {24'd0, out_attr()}, {24'd0, exp_attr[own]});
    check("req_kill_tied", {31'd0, out_req_bits_s1_kill}, 32'd0);
    tick();
    out_req_ready = 1'b0;
    #1;
    check("req_valid_wait", {31'd0, out_req_valid}, 32'd0);
    repeat (dev_delay) tick();
    out_resp_valid = 1'b1;
    out_resp_bits_data = rdata;
    sb_q.push_back('{owner: own, data: rdata});
    #1;
    check("dev_resp_ready_wait", {31'd0, out_resp_ready}, 32'd1);
    tick();
    out_resp_valid = 1'b0;
    out_resp_bits_data = '0;
    #1;
    while (!in0_resp_valid && !in1_resp_valid && n < 20) begin
      tick(); #1; n++;
    end
    e = sb_q.pop_front();
    v_own = (e.owner == 0) ? in0_resp_valid : in1_resp_valid;
    v_oth = (e.owner == 0) ? in1_resp_valid : in0_resp_valid;
    d_own = (e.owner == 0) ? in0_resp_bits_data : in1_resp_bits_data;
    check("resp_valid", {31'd0, v_own}, 32'd1);
    check("resp_data", d_own, e.data);
    check("resp_other_quiet", {31'd0, v_oth}, 32'd0);
    check("dev_resp_ready_resp", {31'd0, out_resp_ready}, 32'd0);
    for (int i = 0; i < resp_stall; i++) begin
      tick(); #1;
      v_own = (e.owner == 0) ? in0_resp_valid : in1_resp_valid;
      d_own = (e.owner == 0) ? in0_resp_bits_data : in1_resp_bits_data;
      check("resp_valid_stall", {31'd0, v_own}, 32'd1);
      check("resp_data_stall", d_own, e.data);
    end
    if (e.owner == 0) in0_resp_ready = 1'b1; else in1_resp_ready = 1'b1;
    tick();
    in0_resp_ready = 1'b0;
    in1_resp_ready = 1'b0;
    #1;
    check("resp_done", {31'd0, in0_resp_valid | in1_resp_valid}, 32'd0);
    $display("[TB] txn owner=%0d addr=%h resp=%h", own, exp_addr[own], e.data);
  endtask

  initial begin
    reset = 1'b0;
    in0_req_valid = 0; in0_req_bits_addr = 0; in0_req_bits_data = 0; in0_req_bits_len = 0;
    in0_req_bits_fcn = 0; in0_req_bits_wstrb = 0; in0_req_bits_is_cached = 0; in0_req_bits_s1_kill = 0;
    in0_resp_ready = 0;
    in1_req_valid = 0; in1_req_bits_addr = 0; in1_req_bits_data = 0; in1_req_bits_len = 0;
    in1_req_bits_fcn = 0; in1_req_bits_wstrb = 0; in1_req_bits_is_cached = 0; in1_req_bits_s1_kill = 0;
    in1_resp_ready = 0;
    out_req_ready = 0; out_resp_valid = 0; out_resp_bits_data = 0;

    // Reset state, with a request already pending
    repeat (2) tick();
    in0_req_valid = 1'b1;
    #1;
    check("rst_in0_req_ready", {31'd0, in0_req_ready}, 32'd0);
    check("rst_out_req_valid", {31'd0, out_req_valid}, 32'd0);
    check("rst_out_resp_ready", {31'd0, out_resp_ready}, 32'd0);
    check("rst_in0_resp_valid", {31'd0, in0_resp_valid}, 32'd0);
    check("rst_resp_data", in0_resp_bits_data, 32'd0);
    check("rst_req_addr", out_req_bits_addr, 32'd0);
    in0_req_valid = 1'b0;
    reset = 1'b1;
    tick();

    // in0 read, device answers two cycles after the handshake
    drive_req(0, 32'h4000_0000, 32'h0, 2'd2, 1'b0, 4'hF, 1'b1);
    wait_grant(0);
    serve(0, 2, 32'h1234_5678, 0);

    // Reset asserted in WAIT, stale response afterwards
    drive_req(0, 32'h4000_0040, 32'h0, 2'd0, 1'b0, 4'h0, 1'b0);
    wait_grant(0);
    out_req_ready = 1'b1;
    tick();
    out_req_ready = 1'b0;
    tick();
    in1_req_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("async_out_resp_ready", {31'd0, out_resp_ready}, 32'd0);
    check("async_in1_req_ready", {31'd0, in1_req_ready}, 32'd0);
    check("async_out_req_valid", {31'd0, out_req_valid}, 32'd0);
    check("async_resp_data", in0_resp_bits_data, 32'd0);
    in1_req_valid = 1'b0;
    out_resp_valid = 1'b1;
    out_resp_bits_data = 32'hBAD0_0001;
    tick();
    reset = 1'b1;
    tick();
    out_resp_valid = 1'b0;
    out_resp_bits_data = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stale_no_resp", {31'd0, in0_resp_valid | in1_resp_valid}, 32'd0);
      tick();
    end
    drive_req(1, 32'h4000_0080, 32'h0, 2'd1, 1'b0, 4'h3, 1'b0);
    wait_grant(1);
    serve(0, 1, 32'hCAFE_0001, 0);

    // Both requesting for four back-to-back transactions: in0, in1, in0, in1
    drive_req(0, 32'h1000_0000, 32'hA0A0_0000, 2'd0, 1'b1, 4'h1, 1'b0);
    drive_req(1, 32'h2000_0000, 32'hB0B0_0000, 2'd3, 1'b1, 4'h8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_grant(k % 2);
      serve(0, 1, 32'h5500_0000 + k, 0);
      drive_req(k % 2, 32'h3000_0000 + 32'(k * 16), 32'hC0DE_0000 + k, 2'(k), k[0], 4'(k + 1), ~k[0]);
    end
    in0_req_valid = 1'b0;
    in1_req_valid = 1'b0;

    // Device stalls out_req_ready for 10 cycles; leaves in1 with priority
    drive_req(0, 32'h4444_0000, 32'h0BAD_F00D, 2'd2, 1'b1, 4'h6, 1'b1);
    wait_grant(0);
    serve(10, 0, 32'h7777_0000, 0);

    // in1 write accepted then killed; pointer must still move to in0
    drive_req(1, 32'h5555_0000, 32'hFEED_0000, 2'd0, 1'b1, 4'hF, 1'b0);
    wait_grant(1);
    in1_req_bits_s1_kill = 1'b1;
    #1;
    check("kill_req_valid", {31'd0, out_req_valid}, 32'd0);
    tick();
    in1_req_bits_s1_kill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("kill_no_req", {31'd0, out_req_valid}, 32'd0);
      check("kill_no_resp", {31'd0, in1_resp_valid}, 32'd0);
      tick();
    end
    $display("[TB] txn owner=1 addr=%h killed", exp_addr[1]);
    drive_req(0, 32'h6666_0000, 32'h0, 2'd1, 1'b0, 4'h0, 1'b1);
    drive_req(1, 32'h6666_1000, 32'h1111_2222, 2'd2, 1'b1, 4'hC, 1'b0);
    wait_grant(0);
    serve(0, 0, 32'h8888_0000, 0);

    // in1 holds resp_ready low for 5 cycles
    wait_grant(1);
    serve(0, 3, 32'h9999_0001, 5);

`ifdef DEVICE_ARB_TIMEOUT_EN
    begin
      int n = 0;
      drive_req(0, 32'h7000_0000, 32'h0, 2'd0, 1'b0, 4'h0, 1'b0);
      wait_grant(0);
      out_req_ready = 1'b1;
      tick();
      out_req_ready = 1'b0;
      sb_q.push_back('{owner: 0, data: 32'hDEADBEEF});
      #1;
      while (!in0_resp_valid && n < 30) begin
        tick(); #1; n++;
      end
      check("timeout_wait_cycles", n, 32'd8);
      check("timeout_data", in0_resp_bits_data, sb_q.pop_front().data);
      in0_resp_ready = 1'b1;
      tick();
      in0_resp_ready = 1'b0;
      out_resp_valid = 1'b1;
      out_resp_bits_data = 32'h0BAD_0BAD;
      tick();
      out_resp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        #1;
        check("timeout_stray_ignored", {31'd0, in0_resp_valid | in1_resp_valid}, 32'd0);
        tick();
      end
      $display("[TB] txn owner=0 addr=%h timeout", exp_addr[0]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
